// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: AND/OR/ADD/SUB finish in one cycle, MUL runs a radix-2
// shift-add loop over WIDTH cycles. All outputs are registered.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             Ovf_o,
  output logic             Err_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] sum, diff, res;
  logic             ovf, err;
  logic             accept, mul_last;

  assign ready_o  = (state == IDLE);
  assign accept   = valid_i && ready_o;
  assign mul_last = (state == MUL) && (count == CW'(WIDTH - 1));
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign sum      = data1_i + data2_i;
  assign diff     = data1_i - data2_i;

  // Single-cycle result path; MUL is handled by the iterative datapath.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    err = 1'b0;
    case (ALUCtrl_i)
      OP_AND: res = data1_i & data2_i;
      OP_OR:  res = data1_i | data2_i;
      OP_ADD: begin
        res = sum;
        ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
              (sum[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
              (diff[WIDTH-1] != data1_i[WIDTH-1]);
      end
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ALUCtrl_i == OP_MUL) state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers only change on a completion, so partial products stay hidden.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
      Ovf_o   <= 1'b0;
      Err_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        if (ALUCtrl_i == OP_MUL) begin
          acc    <= '0;
          mcand  <= data1_i;
          mplier <= data2_i;
          count  <= '0;
        end else begin
          valid_o <= 1'b1;
          data_o  <= res;
          Zero_o  <= (res == '0);
          Ovf_o   <= ovf;
          Err_o   <= err;
        end
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= mul_last ? '0 : count + 1'b1;
        if (mul_last) begin
          valid_o <= 1'b1;
          data_o  <= acc_step;
          Zero_o  <= (acc_step == '0);
          Ovf_o   <= 1'b0;
          Err_o   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  operation request qualifier.
REQ-005 SHALL have port ALUCtrl_i  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL; all other codes illegal.
REQ-006 SHALL have ports data1_i, data2_i  input  WIDTH  operands.
REQ-007 SHALL have port ready_o  output  1  block can accept an operation this cycle.
REQ-008 SHALL have port valid_o  output  1  one-cycle pulse: data_o and flags are new.
REQ-009 SHALL have port data_o  output  WIDTH  registered result.
REQ-010 SHALL have port Zero_o  output  1  registered; 1 iff data_o == 0.
REQ-011 SHALL have port Ovf_o  output  1  registered signed overflow for ADD/SUB; 0 for all other ops.
REQ-012 SHALL have port Err_o  output  1  registered; 1 iff the last completed op was illegal.

Function
REQ-013 SHALL implement FSM states IDLE and MUL; ready_o = 1 only in IDLE.
REQ-014 SHALL accept an operation on a rising edge where valid_i && ready_o; operands and opcode are captured at acceptance; valid_i while ready_o=0 is ignored, not queued.
REQ-015 SHALL complete AND/OR/ADD/SUB and illegal ops in one cycle: accept at edge T, valid_o=1 and results visible after edge T, valid_o=0 after edge T+1 unless another op completes; FSM stays IDLE.
REQ-016 SHALL support back-to-back single-cycle ops: one accept and one completion per cycle, sustained.
REQ-017 SHALL compute ADD/SUB modulo 2^WIDTH; Ovf_o = operand signs equal (ADD) / differ (SUB) and result sign differs from data1_i sign.
REQ-018 SHALL execute MUL iteratively, radix-2 shift-add, one multiplier bit per cycle, internal counter of ceil(log2(WIDTH)) bits: accept at T -> IDLE to MUL; WIDTH iterations in MUL; valid_o pulses after edge T+WIDTH; FSM returns to IDLE at that same edge; ready_o=1 from then.
REQ-019 SHALL output the low WIDTH bits of the unsigned product for MUL; upper bits discarded; Ovf_o=0.
REQ-020 SHALL, for an illegal opcode, produce data_o=0, Zero_o=1, Ovf_o=0, Err_o=1; Err_o clears on the next legal completion.
REQ-021 SHALL hold data_o, Zero_o, Ovf_o, Err_o stable between completions; valid_o is never high two cycles for one op.
REQ-022 SHALL not change data_o or flags during MUL iterations; only the final result is published.
REQ-023 SHALL give MUL with either operand 0 the full WIDTH-cycle latency (no early termination).

Reset
REQ-024 SHALL, when rst_i=1 at an edge, force state IDLE, counter 0, valid_o=0, data_o=0, Zero_o=1, Ovf_o=0, Err_o=0; ready_o=1 after that edge.
REQ-025 SHALL, on reset during MUL, abandon the operation with no valid_o pulse for it.
REQ-026 SHALL give rst_i priority over a simultaneous valid_i; that request is dropped.

Verification (WIDTH=32 unless stated)
REQ-027 SHALL cover: reset -> ready_o=1, valid_o=0, data_o=0, Zero_o=1, Ovf_o=0, Err_o=0.
REQ-028 SHALL cover: ADD 0x7FFFFFFF+1 then SUB 5-5 on consecutive cycles -> valid_o two cycles: 0x80000000 Ovf_o=1 Zero_o=0, then 0 Zero_o=1 Ovf_o=0.
REQ-029 SHALL cover: MUL 0x00010003 x 0x00020005 -> ready_o=0 for 32 cycles, valid_o exactly 32 edges after accept, data_o=0x000B000F, Ovf_o=0; valid_i asserted mid-MUL produces no extra result.
REQ-030 SHALL cover: opcode 111 with operands 0xFFFFFFFF, 1 -> next cycle data_o=0, Zero_o=1, Err_o=1; following AND 0xF0F0 & 0xFF00 -> 0xF000, Err_o=0.
REQ-031 SHALL cover: MUL accepted, rst_i=1 at 10th cycle -> no valid_o, ready_o=1 next cycle, data_o=0.
REQ-032 SHALL cover: WIDTH=8, MUL 0x10 x 0x11 -> valid_o 8 edges after accept, data_o=0x10 (truncated), OR 0xA0|0x0A -> 0xAA.
